ddr_frame_sched: RTL and testbench

Frame scheduler sitting in front of the ten-channel ADC RAM read controller. It collects per-channel "block written" events from the ADC capture side and fires a one-cycle `data_ddr_flag` launch pulse once every channel holds a complete block and the DDR write path is ready. It then counts the `data_valid` words produced by the read controller until the frame has drained, and returns to idle. It also flags channel overruns and drain timeouts.

---
 rtl/ddr_frame_sched_if.sv | 27 ++
 rtl/ddr_frame_sched.sv | 130 +++++++++++++
 tb/tb_ddr_frame_sched.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_frame_sched_if.sv
// Handshake bundle between the ADC capture / read-controller side and the frame scheduler.
// The master drives the capture events and strobes; the slave is the scheduler.
interface ddr_frame_sched_if #(
  parameter int unsigned NUM_CH = 10
);
  logic [NUM_CH-1:0] ch_wr_done;
  logic              ddr_ready;
  logic              data_valid;
  logic              clr_err;
  logic              data_ddr_flag;
  logic              busy;
  logic              frame_done;
  logic [15:0]       frame_cnt;
  logic              overrun;
  logic [NUM_CH-1:0] overrun_ch;
  logic              drain_err;

  modport master (
    output ch_wr_done, ddr_ready, data_valid, clr_err,
    input  data_ddr_flag, busy, frame_done, frame_cnt, overrun, overrun_ch, drain_err
  );

  modport slave (
    input  ch_wr_done, ddr_ready, data_valid, clr_err,
    output data_ddr_flag, busy, frame_done, frame_cnt, overrun, overrun_ch, drain_err
  );
endinterface

// File: rtl/ddr_frame_sched.sv
// Frame scheduler: waits for a block from every channel plus DDR readiness, launches one
// frame read, counts the drained words, and tracks channel overruns and drain timeouts.
module ddr_frame_sched #(
  parameter int unsigned NUM_CH    = 10,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned DRAIN_TO  = 255
) (
  input  logic            clk_ps,
  input  logic            rst_n,
  ddr_frame_sched_if.slave bus
);

  localparam int unsigned FRAME_WORDS = NUM_CH * BURST_LEN;
  localparam int unsigned WC_W        = 7;
  localparam int unsigned TO_W        = 8;
  localparam int unsigned FC_W        = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  logic [NUM_CH-1:0] r_pending;
  logic [WC_W-1:0]   r_word_cnt;
  logic [TO_W-1:0]   r_to_cnt;
  logic              r_flag;
  logic              r_busy;
  logic              r_frame_done;
  logic [FC_W-1:0]   r_frame_cnt;
  logic              r_overrun;
  logic [NUM_CH-1:0] r_overrun_ch;
  logic              r_drain_err;

  logic [NUM_CH-1:0] w_ovr_set;
  logic              w_in_drain;
  logic              w_last_word;
  logic              w_timeout;
  logic              w_to_set;

  // A repeat block on a still-pending channel is an overrun, except in DONE where it
  // belongs to the next frame.
  assign w_ovr_set   = bus.ch_wr_done & r_pending & {NUM_CH{r_state != ST_DONE}};
  assign w_in_drain  = (r_state == ST_DRAIN);
  assign w_last_word = w_in_drain && bus.data_valid && (r_word_cnt == WC_W'(FRAME_WORDS - 1));
  assign w_timeout   = w_in_drain && (r_to_cnt == TO_W'(DRAIN_TO - 1));
  assign w_to_set    = w_timeout && !w_last_word;

  always_ff @(posedge clk_ps or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_pending    <= '0;
      r_word_cnt   <= '0;
      r_to_cnt     <= '0;
      r_flag       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_overrun    <= 1'b0;
      r_overrun_ch <= '0;
      r_drain_err  <= 1'b0;
    end else begin
      r_flag       <= 1'b0;
      r_frame_done <= 1'b0;
      r_pending    <= r_pending | bus.ch_wr_done;

      // Sticky errors: a set in the same cycle as clr_err wins.
      r_overrun_ch <= (r_overrun_ch & {NUM_CH{~bus.clr_err}}) | w_ovr_set;
      r_overrun    <= (r_overrun & ~bus.clr_err) | (|w_ovr_set);
      r_drain_err  <= (r_drain_err & ~bus.clr_err) | w_to_set;

      case (r_state)
        ST_IDLE: begin
          if (&r_pending) begin
            r_state <= ST_ARM;
            r_busy  <= 1'b1;
          end
        end
        ST_ARM: begin
          if (bus.ddr_ready) begin
            r_state <= ST_LAUNCH;
            r_flag  <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          r_state    <= ST_DRAIN;
          r_word_cnt <= '0;
          r_to_cnt   <= '0;
        end
        ST_DRAIN: begin
          if (bus.data_valid) begin
            r_word_cnt <= r_word_cnt + WC_W'(1);
          end
          if (r_to_cnt != {TO_W{1'b1}}) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
          if (w_last_word) begin
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + FC_W'(1);
          end else if (w_timeout) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Pending restarts from whatever arrives this cycle.
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_pending <= bus.ch_wr_done;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_ddr_flag = r_flag;
  assign bus.busy          = r_busy;
  assign bus.frame_done    = r_frame_done;
  assign bus.frame_cnt     = r_frame_cnt;
  assign bus.overrun       = r_overrun;
  assign bus.overrun_ch    = r_overrun_ch;
  assign bus.drain_err     = r_drain_err;

endmodule

// File: tb/tb_ddr_frame_sched.sv
// Directed bench for ddr_frame_sched: a launch-sequence vector table plus hand-written
// sequences for ready gating, overrun, timeout, DONE-cycle events and mid-frame reset.
module tb_ddr_frame_sched;

  localparam int unsigned NUM_CH = 10;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   flag_pulses;

  ddr_frame_sched_if #(.NUM_CH(NUM_CH)) bus ();

  ddr_frame_sched #(.NUM_CH(NUM_CH), .BURST_LEN(8), .DRAIN_TO(255)) dut (
    .clk_ps (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.data_ddr_flag) flag_pulses <= flag_pulses + 1;
  end

  typedef struct {
    logic [NUM_CH-1:0] ch;
    logic              rdy;
    logic              dv;
    logic              exp_flag;
    logic              exp_busy;
    logic              exp_done;
    logic [15:0]       exp_fcnt;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic [NUM_CH-1:0] ch, input logic dv, input logic clr);
    bus.ch_wr_done = ch;
    bus.data_valid = dv;
    bus.clr_err    = clr;
    @(posedge clk);
    #1;
    bus.ch_wr_done = '0;
    bus.data_valid = 1'b0;
    bus.clr_err    = 1'b0;
  endtask

  task automatic fill_all();
    for (int i = 0; i < NUM_CH; i++) step(NUM_CH'(1 << i), 1'b0, 1'b0);
  endtask

  // Steps idle cycles until the launch pulse is visible, bounded.
  task automatic wait_flag(input string nm);
    for (int i = 0; i < 20; i++) begin
      if (bus.data_ddr_flag) break;
      step('0, 1'b0, 1'b0);
    end
    chk(nm, 32'(bus.data_ddr_flag), 32'd1);
  endtask

  // Called with the DUT in LAUNCH: the strobe in that cycle must be ignored, then 80 words.
  task automatic launch_drain(input string nm, input logic [15:0] fcnt_after);
    step('0, 1'b1, 1'b0);
    for (int i = 1; i <= 80; i++) begin
      step('0, 1'b1, 1'b0);
      chk({nm, "_frame_done"}, 32'(bus.frame_done), (i == 80) ? 32'd1 : 32'd0);
    end
    chk({nm, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(fcnt_after));
    step('0, 1'b0, 1'b0);
    chk({nm, "_done_gone"}, 32'(bus.frame_done), 32'd0);
    chk({nm, "_busy_low"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    flag_pulses    = 0;
    rst_n          = 1'b0;
    bus.ch_wr_done = '0;
    bus.ddr_ready  = 1'b1;
    bus.data_valid = 1'b0;
    bus.clr_err    = 1'b0;

    // Rows 0..9: one channel per cycle; 10: IDLE->ARM; 11: LAUNCH; 12: LAUNCH->DRAIN with dv ignored.
    for (int i = 0; i < NUM_CH; i++) tbl[i] = '{NUM_CH'(1 << i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0};
    tbl[10] = '{'0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[11] = '{'0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0};
    tbl[12] = '{'0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_flag", 32'(bus.data_ddr_flag), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_fcnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    chk("rst_ovr_ch", 32'(bus.overrun_ch), 32'd0);
    chk("rst_derr", 32'(bus.drain_err), 32'd0);
    rst_n = 1'b1;

    // Basic frame through the vector table.
    for (int r = 0; r < 13; r++) begin
      bus.ddr_ready = tbl[r].rdy;
      step(tbl[r].ch, tbl[r].dv, 1'b0);
      chk($sformatf("t%0d_flag", r), 32'(bus.data_ddr_flag), 32'(tbl[r].exp_flag));
      chk($sformatf("t%0d_busy", r), 32'(bus.busy), 32'(tbl[r].exp_busy));
      chk($sformatf("t%0d_done", r), 32'(bus.frame_done), 32'(tbl[r].exp_done));
      chk($sformatf("t%0d_fcnt", r), 32'(bus.frame_cnt), 32'(tbl[r].exp_fcnt));
    end
    for (int i = 1; i <= 80; i++) begin
      step('0, 1'b1, 1'b0);
      chk("f1_frame_done", 32'(bus.frame_done), (i == 80) ? 32'd1 : 32'd0);
    end
    step('0, 1'b0, 1'b0);
    chk("f1_fcnt", 32'(bus.frame_cnt), 32'd1);
    chk("f1_busy", 32'(bus.busy), 32'd0);
    chk("f1_flag_pulses", 32'(flag_pulses), 32'd1);

    // DDR not ready: no launch while low, launch on the first ARM cycle with ready high.
    bus.ddr_ready = 1'b0;
    fill_all();
    for (int i = 0; i < 50; i++) begin
      step('0, 1'b0, 1'b0);
      chk("rdy_low_flag", 32'(bus.data_ddr_flag), 32'd0);
    end
    chk("rdy_low_busy", 32'(bus.busy), 32'd1);
    bus.ddr_ready = 1'b1;
    step('0, 1'b0, 1'b0);
    chk("rdy_rise_flag", 32'(bus.data_ddr_flag), 32'd1);
    bus.ddr_ready = 1'b0;
    launch_drain("f2", 16'd2);
    chk("f2_flag_pulses", 32'(flag_pulses), 32'd2);
    bus.ddr_ready = 1'b1;

    // Overrun on channel 3.
    for (int i = 0; i < 5; i++) step(NUM_CH'(1 << i), 1'b0, 1'b0);
    chk("ovr_not_yet", 32'(bus.overrun), 32'd0);
    step(NUM_CH'(1 << 3), 1'b0, 1'b0);
    chk("ovr_set", 32'(bus.overrun), 32'd1);
    chk("ovr_ch", 32'(bus.overrun_ch), 32'h008);
    for (int i = 5; i < NUM_CH; i++) step(NUM_CH'(1 << i), 1'b0, 1'b0);
    wait_flag("f3_flag");
    launch_drain("f3", 16'd3);
    chk("ovr_kept", 32'(bus.overrun_ch), 32'h008);
    step('0, 1'b0, 1'b1);
    chk("clr_ovr", 32'(bus.overrun), 32'd0);
    chk("clr_ovr_ch", 32'(bus.overrun_ch), 32'd0);
    chk("clr_derr", 32'(bus.drain_err), 32'd0);

    // Drain timeout after 40 words: DRAIN lasts exactly 255 cycles.
    fill_all();
    wait_flag("f4_flag");
    for (int n = 1; n <= 257; n++) begin
      step('0, (n >= 2 && n <= 41), 1'b0);
      chk("to_no_done", 32'(bus.frame_done), 32'd0);
      if (n == 255) chk("to_derr_early", 32'(bus.drain_err), 32'd0);
      if (n == 256) chk("to_derr_set", 32'(bus.drain_err), 32'd1);
      if (n == 256) chk("to_busy_done", 32'(bus.busy), 32'd1);
    end
    chk("to_fcnt", 32'(bus.frame_cnt), 32'd3);
    chk("to_idle", 32'(bus.busy), 32'd0);
    step('0, 1'b0, 1'b1);
    chk("to_clr", 32'(bus.drain_err), 32'd0);

    // ch5 in the DONE cycle is carried into the next frame without an overrun.
    fill_all();
    wait_flag("f5_flag");
    step('0, 1'b1, 1'b0);
    for (int i = 1; i <= 80; i++) step('0, 1'b1, 1'b0);
    chk("f5_done", 32'(bus.frame_done), 32'd1);
    step(NUM_CH'(1 << 5), 1'b0, 1'b0);
    chk("done_ch5_no_ovr", 32'(bus.overrun), 32'd0);
    chk("done_ch5_pending", 32'(dut.r_pending), 32'h020);
    step(NUM_CH'(1 << 5), 1'b0, 1'b1);
    chk("set_wins_ovr", 32'(bus.overrun), 32'd1);
    chk("set_wins_ch", 32'(bus.overrun_ch), 32'h020);
    step('0, 1'b0, 1'b1);
    chk("set_wins_clr", 32'(bus.overrun_ch), 32'd0);
    for (int i = 0; i < NUM_CH; i++) if (i != 5) step(NUM_CH'(1 << i), 1'b0, 1'b0);
    wait_flag("f6_flag");
    launch_drain("f6", 16'd5);
    chk("f6_no_ovr", 32'(bus.overrun), 32'd0);

    // Asynchronous reset in the middle of DRAIN.
    fill_all();
    wait_flag("f7_flag");
    for (int i = 0; i < 21; i++) step('0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_fcnt", 32'(bus.frame_cnt), 32'd0);
    chk("mid_rst_flag", 32'(bus.data_ddr_flag), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    fill_all();
    wait_flag("f8_flag");
    launch_drain("f8", 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

endmodule
